// File: rtl/slice_pack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_pack_pkg - shared widths, beat map and FSM state type          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package slice_pack_pkg;

  localparam int NIBBLE_W = 4;
  localparam int WORD_W   = 16;
  localparam int BEATS    = 4;
  localparam int CNT_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Beat b lands at out[b*NIBBLE_W +: NIBBLE_W].
  function automatic int beat_lsb(input int b);
    return b * NIBBLE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slice_pack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_pack_if - nibble-in / word-out handshake bundle                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface slice_pack_if;
  import slice_pack_pkg::*;

  logic [NIBBLE_W-1:0] in;
  logic                in_valid;
  logic                in_first;
  logic                in_ready;
  logic [WORD_W-1:0]   out;
  logic                out_valid;
  logic                out_ready;
  logic                err;

  modport master (
    output in, in_valid, in_first, out_ready,
    input  in_ready, out, out_valid, err
  );

  modport slave (
    input  in, in_valid, in_first, out_ready,
    output in_ready, out, out_valid, err
  );

endinterface
`default_nettype wire

// File: rtl/slice_pack_outreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_pack_outreg - one-entry valid/ready word register              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slice_pack_outreg
  import slice_pack_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              arst_n,
  input  wire logic              load_i,
  input  wire logic [WORD_W-1:0] data_i,
  input  wire logic              ready_i,
  output logic                   valid_o,
  output logic      [WORD_W-1:0] data_o
);

  logic              valid_q;
  logic [WORD_W-1:0] data_q;

  // The producer only loads when the slot is empty or draining this cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/slice_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_pack - packs four framed nibble beats into a 16-bit word       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slice_pack
  import slice_pack_pkg::*;
#(
  parameter bit SWAP_B0 = 1'b1
) (
  input  wire logic  clk,
  input  wire logic  arst_n,
  slice_pack_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic                err_q, err_d;
  logic [NIBBLE_W-1:0] b0_nib;
  logic                in_rdy;
  logic                accept;
  logic                load;
  logic                out_vld;
  logic [WORD_W-1:0]   out_word;
  logic [WORD_W-1:0]   load_word;

  if (SWAP_B0) begin : g_swap
    assign b0_nib = {bus.in[1:0], bus.in[3:2]};
  end else begin : g_noswap
    assign b0_nib = bus.in;
  end

  // Only the completing beat needs the output slot, so beats 0-2 flow during a stall.
  assign in_rdy    = (cnt_q != LAST_BEAT) || !out_vld || bus.out_ready;
  assign accept    = bus.in_valid && in_rdy;
  assign load_word = {bus.in, acc_q[WORD_W-NIBBLE_W-1:0]};

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    err_d = 1'b0;
    load  = 1'b0;
    if (accept) begin
      if (bus.in_first) begin
        err_d                 = (state_q != ST_IDLE);
        acc_d                 = '0;
        acc_d[NIBBLE_W-1:0]   = b0_nib;
        cnt_d                 = CNT_W'(1);
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        for (int b = 1; b < BEATS; b++) begin
          if (cnt_q == CNT_W'(b)) begin
            acc_d[beat_lsb(b) +: NIBBLE_W] = bus.in;
          end
        end
        load  = (cnt_q == LAST_BEAT);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    state_d = (cnt_d == '0) ? ST_IDLE : ST_FILL;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  slice_pack_outreg u_outreg (
    .clk     (clk),
    .arst_n  (arst_n),
    .load_i  (load),
    .data_i  (load_word),
    .ready_i (bus.out_ready),
    .valid_o (out_vld),
    .data_o  (out_word)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out       = out_word;
  assign bus.out_valid = out_vld;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: doc/slice_pack.md
SLICE_PACK -- requirements
Module: slice_pack

Interface
REQ-001 Parameter SWAP_B0, default 1: when 1, nibble beat 0 arrives with its 2-bit halves swapped and SHALL be un-swapped on packing; when 0, beat 0 SHALL pass unchanged.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 arst_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  4  nibble beat.
REQ-005 in_valid  input  1  beat present.
REQ-006 in_first  input  1  marks beat 0 of a word; qualified by in_valid.
REQ-007 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-008 out  output  16  reassembled word, held while out_valid.
REQ-009 out_valid  output  1  word present.
REQ-010 out_ready  input  1  word consumed when out_valid & out_ready.
REQ-011 err  output  1  one-cycle pulse on framing error.

Function
REQ-012 Beat order SHALL be: beat0 -> out[3:0], beat1 -> out[7:4], beat2 -> out[11:8], beat3 -> out[15:12].
REQ-013 With SWAP_B0=1, out[3:0] SHALL equal {beat0[1:0], beat0[3:2]}.
REQ-014 A 2-bit beat counter cnt (0..3) SHALL advance on each accepted beat and wrap from 3 to 0.
REQ-015 State machine: IDLE (cnt=0, no partial word), FILL (cnt=1..3), with a separate 1-entry output register (out_valid).
REQ-016 in_ready SHALL be 1 when cnt!=3, or out_valid=0, or out_ready=1 (beats 0-2 accepted during an output stall).
REQ-017 On accepting beat 3, out and out_valid=1 SHALL update on that same edge (word visible the cycle after beat 3; latency 1 cycle).
REQ-018 out_valid SHALL clear on handshake unless beat 3 is accepted the same cycle, in which case the new word SHALL replace the old with out_valid staying 1 (full throughput: 1 word per 4 beat cycles).
REQ-019 out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Accepted beat with in_first=1 while cnt!=0: partial word SHALL be discarded, err pulses, and the beat SHALL be taken as beat 0 (cnt becomes 1).
REQ-021 Accepted beat with in_first=0 while cnt=0: beat SHALL be dropped, err pulses, cnt stays 0.
REQ-022 in_first on beats accepted at cnt=0 is the normal case and SHALL not raise err.
REQ-023 err SHALL be 0 in every cycle without a framing error; it is registered (asserted the cycle after the offending beat).
REQ-024 No beat SHALL be accepted when in_valid=0; in and in_first are don't-care then.

Reset
REQ-025 On arst_n low: cnt=0, out_valid=0, out=16'h0000, err=0, accumulator=0, immediately and independent of clk.
REQ-026 Reset mid-word SHALL discard the partial word; first accepted beat after release must carry in_first.
REQ-027 in_ready SHALL be 1 during and after reset (cnt=0).

Structure
REQ-028 Shared package SHALL hold NIBBLE_W=4, WORD_W=16, BEATS=4, and the beat-index/bit-range map of REQ-012.
REQ-029 One sub-module, slice_pack_outreg, SHALL implement the 16-bit valid/ready output register; counter, accumulator and framing check stay in slice_pack.

Verification
REQ-030 Beats 0xC,0x5,0xA,0x3 (first on beat0), out_ready=1 -> next cycle out=16'h3A53, out_valid=1 for 1 cycle, err=0.
REQ-031 Same word with SWAP_B0=0 -> out=16'h3A5C.
REQ-032 out_ready=0 after word 1, stream word 2 -> beats 0-2 accepted, in_ready=0 at beat 3 until out_ready=1; word 1 held stable, word 2 then follows without loss.
REQ-033 in_first asserted on 3rd beat of a word -> err pulse, partial discarded, next word packs correctly from that beat.
REQ-034 Beat without in_first at cnt=0 -> dropped, err pulse, cnt=0, no out_valid.
REQ-035 arst_n low after 2 beats -> out_valid=0, out=0 asynchronously; fresh 4-beat word afterwards packs correctly.
